// File: rtl/rv32i_core_sequencer_if.sv
// rv32i_core_sequencer_if: instruction/data memory handshake between the sequencer and memories.
//   InsReq    sequencer -> imem : fetch request at current PC
//   InsReady  imem -> sequencer : instruction data valid
//   MemReq    sequencer -> dmem : data RAM request
//   MemWrite  sequencer -> dmem : data RAM write qualifier
//   MemReady  dmem -> sequencer : data RAM access complete
interface rv32i_core_sequencer_if;
    logic InsReq;
    logic InsReady;
    logic MemReq;
    logic MemWrite;
    logic MemReady;
    modport master (output InsReq, MemReq, MemWrite, input InsReady, MemReady);
    modport slave  (input InsReq, MemReq, MemWrite, output InsReady, MemReady);
endinterface

// File: rtl/rv32i_core_sequencer.sv
// rv32i_core_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control sequencer for the RV32I core.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   Run                 : permits a new fetch (sampled in FETCH only)
//   bus                 : memory handshake (InsReq/InsReady, MemReq/MemWrite/MemReady)
//   decoder flags       : RegWriteControl, LinkAddrWrite, TestBranch, AlwaysBranch, RAMWriteControl, RAMRegRead
//   BranchCond          : branch-condition generator result
//   IRLoad, RegWriteEn, PCWriteEn, PCBranch : single-cycle datapath strobes
//   Trap                : core halted until reset
//   Retired             : retired-instruction count (wraps)
//   State               : current FSM state, for debug
// Optional feature: define SEQ_MEM_TIMEOUT_EN to trap when the data memory stalls for TimeoutCycles MEM cycles.
module rv32i_core_sequencer #(
    parameter int dataW         = 32,
    parameter int TimeoutCycles = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 Run,
    rv32i_core_sequencer_if.master bus,
    input  logic                 RegWriteControl,
    input  logic                 LinkAddrWrite,
    input  logic                 TestBranch,
    input  logic                 AlwaysBranch,
    input  logic                 RAMWriteControl,
    input  logic                 RAMRegRead,
    input  logic                 BranchCond,
    output logic                 IRLoad,
    output logic                 RegWriteEn,
    output logic                 PCWriteEn,
    output logic                 PCBranch,
    output logic                 Trap,
    output logic [dataW-1:0]     Retired,
    output logic [2:0]           State
);
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd7
    } state_t;

    state_t           state;
    logic [dataW-1:0] retired;
    logic             timeout;
    logic             live;
    logic             wb;
    logic             legal;

    if (TimeoutCycles < 1 || TimeoutCycles > 255) begin : g_bad_timeout
        $error("TimeoutCycles must be in 1..255");
    end

    // LinkAddrWrite is consumed by the datapath directly; the sequencer ignores it.
    logic unused;
    assign unused = LinkAddrWrite;

`ifdef SEQ_MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
    // Held at zero outside MEM so it is clear on MEM entry; the limit is reached
    // in the MEM cycle whose stall would bring the count up to TimeoutCycles.
    assign timeout = (wait_cnt + 8'd1) == 8'(TimeoutCycles);
    always_ff @(posedge clock) begin
        if (reset || state != MEM)
            wait_cnt <= '0;
        else if (!bus.MemReady)
            wait_cnt <= wait_cnt + 8'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    assign legal = RegWriteControl || TestBranch || RAMWriteControl;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= FETCH;
            retired <= '0;
        end else begin
            case (state)
                FETCH:     state <= (Run && bus.InsReady) ? DECODE : FETCH;
                DECODE:    state <= legal ? EXECUTE : TRAP;
                EXECUTE:   state <= RAMRegRead ? MEM : WRITEBACK;
                MEM:       state <= bus.MemReady ? WRITEBACK : (timeout ? TRAP : MEM);
                WRITEBACK: state <= FETCH;
                default:   state <= TRAP;
            endcase
            if (state == WRITEBACK)
                retired <= retired + dataW'(1);
        end
    end

    assign live         = !reset;
    assign wb           = live && state == WRITEBACK;
    assign bus.InsReq   = live && state == FETCH && Run;
    assign IRLoad       = live && state == FETCH && Run && bus.InsReady;
    assign bus.MemReq   = live && state == MEM;
    assign bus.MemWrite = live && state == MEM && RAMWriteControl;
    assign RegWriteEn   = wb && RegWriteControl && !RAMWriteControl;
    assign PCWriteEn    = wb;
    assign PCBranch     = wb && (AlwaysBranch || (TestBranch && BranchCond));
    assign Trap         = live && state == TRAP;
    assign Retired      = live ? retired : '0;
    assign State        = live ? state : 3'd0;
endmodule

// File: tb/tb_rv32i_core_sequencer.sv
// tb_rv32i_core_sequencer: randomized instruction-level check of rv32i_core_sequencer against a per-instruction timeline model.
module tb_rv32i_core_sequencer;
`ifdef SEQ_MEM_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif
    localparam int TO = 4;
    localparam logic [7:0] IRQ = 8'h80, IRL = 8'h40, MRQ = 8'h20, MWR = 8'h10;
    localparam logic [7:0] RWE = 8'h08, PCW = 8'h04, PCB = 8'h02, TRP = 8'h01;

    logic clock = 1'b0, reset = 1'b1, Run = 1'b0;
    logic rwc = 1'b0, law = 1'b0, tbr = 1'b0, ab = 1'b0, rw = 1'b0, rr = 1'b0, bc = 1'b0;
    logic IRLoad, RegWriteEn, PCWriteEn, PCBranch, Trap;
    logic [31:0] Retired;
    logic [2:0] State;

    rv32i_core_sequencer_if bus();

    rv32i_core_sequencer #(.dataW(32), .TimeoutCycles(TO)) dut (
        .clock(clock), .reset(reset), .Run(Run), .bus(bus.master),
        .RegWriteControl(rwc), .LinkAddrWrite(law), .TestBranch(tbr), .AlwaysBranch(ab),
        .RAMWriteControl(rw), .RAMRegRead(rr), .BranchCond(bc),
        .IRLoad(IRLoad), .RegWriteEn(RegWriteEn), .PCWriteEn(PCWriteEn), .PCBranch(PCBranch),
        .Trap(Trap), .Retired(Retired), .State(State)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;
    bit chk_on = 1'b0;
    logic [7:0] exp_s = '0;
    logic [2:0] exp_st = '0;
    logic [31:0] exp_ret = '0;
    int unsigned ret = 0;
    int lat = 0, last_lat = 0;

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            check("strobes", {24'h0, bus.InsReq, IRLoad, bus.MemReq, bus.MemWrite,
                              RegWriteEn, PCWriteEn, PCBranch, Trap}, {24'h0, exp_s});
            check("state", {29'h0, State}, {29'h0, exp_st});
            check("retired", Retired, exp_ret);
        end
    end

    // Cycles from the IRLoad cycle to the PCWriteEn cycle, inclusive.
    always @(negedge clock) begin
        lat = IRLoad ? 1 : lat + 1;
        if (PCWriteEn) last_lat = lat;
    end

    task automatic cyc(input logic run, input logic ir, input logic mr, input logic [7:0] s, input logic [2:0] st);
        Run = run;
        bus.InsReady = ir;
        bus.MemReady = mr;
        exp_s = s;
        exp_st = st;
        exp_ret = ret;
        @(posedge clock);
        #1;
    endtask

    task automatic rst_cyc(input logic mr);
        reset = 1'b1;
        Run = rnd();
        bus.InsReady = rnd();
        bus.MemReady = mr;
        exp_s = '0;
        exp_st = '0;
        exp_ret = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        ret = 0;
    endtask

    task automatic trap_then_reset();
        for (int i = 0; i < 20; i++) cyc(rnd(), rnd(), rnd(), TRP, 3'd7);
        rst_cyc(rnd());
    endtask

    // kind: 0 ALU, 1 branch, 2 JAL, 3 load, 4 store, 5 illegal
    task automatic run_instr(input int kind, input logic cond, input int stall, input int mwait, input bit abort);
        rwc = kind == 0 || kind == 2 || kind == 3;
        tbr = kind == 1;
        ab  = kind == 2;
        law = kind == 2;
        rw  = kind == 4;
        rr  = kind == 3 || kind == 4;
        bc  = cond;
        if (kind == 5) begin
            ab = rnd();
            rr = rnd();
            law = rnd();
        end
        for (int i = 0; i < stall; i++) begin
            logic r;
            r = rnd();
            cyc(r, r ? 1'b0 : rnd(), rnd(), r ? IRQ : 8'h00, 3'd0);
        end
        cyc(1'b1, 1'b1, rnd(), IRQ | IRL, 3'd0);
        cyc(rnd(), rnd(), rnd(), 8'h00, 3'd1);
        if (kind == 5) begin
            trap_then_reset();
            return;
        end
        cyc(rnd(), rnd(), rnd(), 8'h00, 3'd2);
        if (rr) begin
            for (int i = 0; i <= mwait; i++) begin
                logic rdy;
                rdy = i == mwait;
                if (abort) begin
                    rst_cyc(1'b1);
                    return;
                end
                cyc(rnd(), rnd(), rdy, MRQ | (rw ? MWR : 8'h00), 3'd3);
                if (TO_ON && !rdy && i + 1 == TO) begin
                    trap_then_reset();
                    return;
                end
            end
        end
        cyc(rnd(), rnd(), rnd(),
            PCW | ((rwc && !rw) ? RWE : 8'h00) | ((ab || (tbr && cond)) ? PCB : 8'h00), 3'd4);
        ret++;
    endtask

    initial begin
        bus.InsReady = 1'b0;
        bus.MemReady = 1'b0;
        chk_on = 1'b1;
        rst_cyc(1'b0);
        rst_cyc(1'b0);
        run_instr(0, 1'b0, 0, 0, 1'b0);
        check("addi_latency", last_lat, 4);
        check("addi_retired", Retired, 32'd1);
        run_instr(3, 1'b0, 0, 3, 1'b0);
        check("lw_latency", last_lat, 8);
        run_instr(4, 1'b1, 0, 0, 1'b0);
        check("sw_latency", last_lat, 5);
        check("sw_retired", Retired, 32'd3);
        run_instr(1, 1'b0, 1, 0, 1'b0);
        run_instr(1, 1'b1, 2, 0, 1'b0);
        run_instr(2, 1'b0, 0, 0, 1'b0);
        check("jal_latency", last_lat, 4);
        run_instr(3, 1'b0, 0, 0, 1'b1);
        check("abort_retired", Retired, 32'd0);
        for (int n = 0; n < 300; n++)
            run_instr($urandom_range(0, 4), rnd(), $urandom_range(0, 3), $urandom_range(0, 6),
                      $urandom_range(0, 19) == 0);
        run_instr(3, 1'b0, 0, 10, 1'b0);
        run_instr(3, 1'b0, 0, 3, 1'b0);
        run_instr(5, 1'b0, 0, 0, 1'b0);
        check("trap_reset_retired", Retired, 32'd0);
        run_instr(0, 1'b0, 0, 0, 1'b0);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32i_core_sequencer.md
# rv32i_core_sequencer

Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. It gates the RV32I decoder's static control flags into single-cycle strobes for the instruction register, register file, PC and data RAM. It handshakes with instruction and data memory, detects undecodable instructions, and counts retired instructions.

## Interface
Parameters:
- `dataW`, 32: datapath width; `Retired` width.
- `TimeoutCycles`, 15: data-memory wait limit in cycles. Only used with `SEQ_MEM_TIMEOUT_EN`. Legal range 1..255.

Ports:
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `Run`  in  1: permits a new fetch. Sampled only in FETCH.
- `InsReady`  in  1: instruction memory data valid.
- `RegWriteControl`, `LinkAddrWrite`, `TestBranch`, `AlwaysBranch`, `RAMWriteControl`, `RAMRegRead`  in  1 each: decoder flags. Valid from DECODE onward.
- `BranchCond`  in  1: branch-condition generator result.
- `MemReady`  in  1: data RAM access complete.
- `InsReq`  out  1: fetch request at current PC.
- `IRLoad`  out  1: capture instruction into the IR.
- `MemReq`  out  1: data RAM request.
- `MemWrite`  out  1: data RAM write qualifier.
- `RegWriteEn`  out  1: register file write strobe.
- `PCWriteEn`  out  1: PC update strobe.
- `PCBranch`  out  1: PC update takes the branch target; low selects PC+4.
- `Trap`  out  1: core halted.
- `Retired`  out  dataW: retired-instruction count.
- `State`  out  3: current FSM state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=7. Codes 5 and 6 go to TRAP on the next edge.
- Outputs are combinational from state and inputs. They are all forced to 0 while `reset` is high.
- FETCH:
  - `InsReq`=`Run`.
  - When `Run`&`InsReady`: `IRLoad`=1 that cycle, then go to DECODE.
  - When `InsReady` arrives with `Run` low, it is ignored and the state stays FETCH.
- DECODE:
  - Illegal instruction = none of `RegWriteControl`, `TestBranch`, `RAMWriteControl` set. Illegal goes to TRAP.
  - Otherwise go to EXECUTE.
- EXECUTE: one cycle for ALU settle. Go to MEM if `RAMRegRead`, else WRITEBACK.
- MEM:
  - `MemReq`=1 and `MemWrite`=`RAMWriteControl`, held stable until `MemReady`.
  - On `MemReady`, go to WRITEBACK.
- WRITEBACK, exactly one cycle:
  - `RegWriteEn`=`RegWriteControl`&~`RAMWriteControl`.
  - `PCWriteEn`=1.
  - `PCBranch`=`AlwaysBranch`|(`TestBranch`&`BranchCond`).
  - `Retired` increments. Then go to FETCH.
- TRAP: all strobes 0 and `Trap`=1. Exit only by reset.
- `LinkAddrWrite` does not affect sequencing. The datapath uses it directly during the WRITEBACK register write.
- `Retired` wraps from 2^dataW−1 to 0 without flagging.

## Timing
- Reset: at the first edge with `reset` high, state=FETCH, `Retired`=0, `Trap`=0, and any timeout counter=0.
- Reset dominates every other input, including mid-MEM. The RAM must tolerate `MemReq` dropping without `MemReady`.
- Minimum latency, counted from the `IRLoad` cycle to the `PCWriteEn` cycle inclusive:
  - ALU, branch and jump instructions: 4 cycles.
  - Loads and stores: 5 cycles plus the `MemReady` wait.
- Back-to-back operation: the cycle after WRITEBACK is FETCH, so `InsReq` can reassert immediately.
- `MemReady` is ignored outside MEM. `InsReady` is ignored outside FETCH.
- `MemReady` and `reset` high together: reset wins and the access does not retire.
- Run low during DECODE, EXECUTE, MEM or WRITEBACK: the current instruction completes, and the sequencer parks in FETCH with `InsReq`=0.

## Configuration
- `SEQ_MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on MEM entry and increments each MEM cycle without `MemReady`.
  - When it equals `TimeoutCycles` with `MemReady` still low, the next state is TRAP and `MemReq` drops. The instruction does not retire.
  - `MemReady` in the same cycle as the limit is reached takes priority, and the instruction goes to WRITEBACK.
- Undefined: MEM waits indefinitely, `TimeoutCycles` is ignored, and no counter is built.

## Test plan
- ADDI (0x00500093), `InsReady` tied 1, `Run`=1: `IRLoad` at cycle 0, `RegWriteEn`=`PCWriteEn`=1 at cycle 3, `PCBranch`=0, `Retired`=1.
- LW with `MemReady` delayed 3 cycles: `MemReq` held 4 cycles with `MemWrite`=0. Then WRITEBACK with `RegWriteEn`=1. Total 8 cycles.
- SW: `MemWrite`=1 throughout MEM; in WRITEBACK `RegWriteEn`=0, `PCWriteEn`=1.
- BEQ with `BranchCond`=0, then 1: `PCBranch`=0, then 1. JAL with `BranchCond`=0: `PCBranch`=1 and `RegWriteEn`=1.
- All-zero instruction (no decoder flags set): DECODE then TRAP. `Trap` stays 1 for 20 cycles with no strobes. Asserting `reset` returns to FETCH with `Retired`=0.
- With `SEQ_MEM_TIMEOUT_EN` and `TimeoutCycles`=4: LW with `MemReady` never asserted reaches TRAP after 4 MEM cycles and `Retired` is unchanged. Repeat with `MemReady` on the 4th MEM cycle: the instruction retires normally.
